result_nibble_tx: RTL and testbench
===================================

Name: result_nibble_tx

Overview:
- Serializer for the 16-bit Q8.8 result register (R) of the iterative datapath; this is the output-side counterpart of the 4-bit nibble input shifter for X.
- Captures a 16-bit word on a load strobe and emits it as 4-bit nibbles over a valid/ready handshake, least-significant nibble first by default.
- Sits between the datapath controller (drives `loadEn` when the computation completes) and the downstream 4-bit consumer.

Parameters:
- WIDTH, 16, width of the captured word; must be a multiple of 4.
- LSB_FIRST, 1, 1 = send nibble [3:0] first; 0 = send [WIDTH-1:WIDTH-4] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  WIDTH  word to serialize (R register output).
- loadEn  input  1  capture strobe; honoured only in IDLE.
- nib_ready  input  1  downstream ready for the current nibble.
- nib_out  output  4  current nibble.
- nib_valid  output  1  `nib_out` is valid.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse after the last nibble is accepted.
- nib_idx  output  clog2(WIDTH/4)  index of the nibble being presented (0 = first sent).

Behaviour:
- Reset (async, active-high): state=IDLE; shift register=0; nib_idx=0; nib_out=0; nib_valid=0; busy=0; done=0.
- States:
  - IDLE: `loadEn` → capture `load` into the shift register, nib_idx=0, go to SEND next edge.
  - SEND: present the nibble; on `nib_valid && nib_ready`, shift by 4 toward the send end, nib_idx+1.
  - SEND → IDLE: on the handshake of the last nibble (nib_idx = WIDTH/4-1); done=1 for exactly the following cycle.
- Latency:
  - `loadEn` sampled at edge k → first nibble valid in cycle k+1.
  - With `nib_ready` held high, nibbles are accepted at edges k+1..k+4 (WIDTH=16); done is high in cycle k+5.
- Output rules:
  - `nib_out` is driven directly from the shift-register end (registered, no combinational path from `load`).
  - `nib_valid` = (state == SEND).
  - `busy` = `nib_valid`.
- Backpressure: while `nib_valid && !nib_ready`, `nib_out` and `nib_idx` hold stable. `nib_valid` never deasserts before its handshake.
- `loadEn` while busy: ignored; the in-flight word is unaffected and no error is flagged. The controller is required to wait for `done` or `!busy`.
- `loadEn` in the done cycle: state is IDLE, so it is accepted (back-to-back words with zero bubble beyond the done cycle).
- `loadEn` and `rst` together: reset wins.
- Reset mid-SEND: the word is discarded; no done pulse.
- Shift fill: bits vacated by shifting fill with 0. In IDLE after completion, `nib_out` therefore reads 0.
- MSB-first mode (LSB_FIRST=0): shift direction is reversed; everything else is identical.

Decomposition:
- Shared package holds:
  - state encoding `tx_state_t` {IDLE, SEND}.
  - constant `NIB_W=4`.
  - constant `Q88_ONE=16'h0100`, shared with the R/T init logic.
- One natural sub-module, `nib_shifter`: WIDTH-bit register with load, 4-bit shift enable and LSB_FIRST direction. The FSM, counter and handshake stay in the top.

Test Plan:
1. Reset then idle: assert rst mid-cycle → all outputs 0 asynchronously. Hold 5 cycles with no `loadEn` → `nib_valid` stays 0.
2. Basic send: load=16'h0100, `loadEn` 1 cycle, `nib_ready`=1 → nibbles 0,0,1,0 on consecutive cycles with nib_idx 0..3; done pulses once; busy high exactly 4 cycles.
3. Backpressure: load=16'hA5C3, `nib_ready` toggled 1,0,0,1,0,1,1 → accepted nibbles are 3,C,5,A. `nib_out` is stable during every stall.
4. Busy load ignored: load=16'h1234; pulse `loadEn` with load=16'hFFFF during the second nibble → output is still 4,3,2,1; single done pulse.
5. Back-to-back: first word 16'h0F0F, then second word 16'hBEEF loaded in the done cycle → 4+4 nibbles (F,0,F,0,F,E,E,B) with a one-cycle gap; two done pulses.
6. Reset mid-operation, plus MSB-first build: assert rst after 2 nibbles of 16'h1234 → outputs clear immediately, no done, and a subsequent load works normally. In a LSB_FIRST=0 build, 16'h1234 is sent as 1,2,3,4.

Source files
------------

// File: rtl/result_nibble_tx_pkg.sv
// result_nibble_tx_pkg: shared state encoding and constants for the result nibble serializer.
// Contents: tx_state_t (IDLE/SEND), NIB_W (nibble width), Q88_ONE (Q8.8 value 1.0, shared with R/T init).
package result_nibble_tx_pkg;
  typedef enum logic {IDLE, SEND} tx_state_t;
  localparam int NIB_W = 4;
  localparam logic [15:0] Q88_ONE = 16'h0100;
endpackage

// File: rtl/result_nibble_tx_nib_shifter.sv
// nib_shifter: WIDTH-bit word register with parallel load and nibble shift toward the send end.
// Ports: clk, rst (async, active high); ld/d parallel load; shift moves one nibble out (zero fill);
//        nib is the nibble currently at the send end.
module nib_shifter
  import result_nibble_tx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             shift,
  output logic [NIB_W-1:0] nib
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (ld) sr <= d;
    else if (shift) sr <= (LSB_FIRST != 0) ? (sr >> NIB_W) : (sr << NIB_W);
  assign nib = (LSB_FIRST != 0) ? sr[NIB_W-1:0] : sr[WIDTH-1 -: NIB_W];
endmodule

// File: rtl/result_nibble_tx.sv
// result_nibble_tx: serializes a captured WIDTH-bit result word as 4-bit nibbles over valid/ready.
// Ports: clk, rst (async, active high); load/loadEn capture a word (IDLE only);
//        nib_out/nib_valid/nib_ready nibble handshake; busy while sending;
//        done pulses one cycle after the last nibble is accepted; nib_idx is the presented nibble index.
module result_nibble_tx
  import result_nibble_tx_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int LSB_FIRST = 1,
  localparam int NN        = WIDTH / NIB_W,
  localparam int IW        = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load,
  input  logic             loadEn,
  input  logic             nib_ready,
  output logic [NIB_W-1:0] nib_out,
  output logic             nib_valid,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    nib_idx
);
  tx_state_t state, state_nx;
  logic      ld, hs, last;
  assign ld   = (state == IDLE) && loadEn;
  assign hs   = nib_valid && nib_ready;
  assign last = nib_idx == IW'(NN - 1);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = loadEn ? SEND : IDLE;
    else state_nx = (hs && last) ? IDLE : SEND;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      nib_idx <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      done    <= hs && last;
      if (ld) nib_idx <= '0;
      else if (hs) nib_idx <= last ? '0 : nib_idx + 1'b1;
    end
  // The final shift empties the register, so nib_out reads 0 once back in IDLE.
  nib_shifter #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_shift (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .d    (load),
    .shift(hs),
    .nib  (nib_out)
  );
  assign nib_valid = state == SEND;
  assign busy      = nib_valid;
endmodule

// File: tb/tb_result_nibble_tx.sv
// tb_result_nibble_tx: directed scoreboard bench for result_nibble_tx (LSB-first and MSB-first builds).
module tb_result_nibble_tx;
  import result_nibble_tx_pkg::*;
  logic clk = 0, rst = 0;
  logic [15:0] load = 0, load_m = 0;
  logic loadEn = 0, loadEn_m = 0, nib_ready = 1, ready_m = 1;
  logic [3:0] nib_out, nib_out_m;
  logic nib_valid, busy, done, nib_valid_m, busy_m, done_m;
  logic [1:0] nib_idx, nib_idx_m;
  int n_chk = 0, n_fail = 0, busy_cyc = 0;
  logic [5:0] q[$], qm[$];
  always #5 clk = ~clk;

  result_nibble_tx dut (
    .clk(clk), .rst(rst), .load(load), .loadEn(loadEn), .nib_ready(nib_ready),
    .nib_out(nib_out), .nib_valid(nib_valid), .busy(busy), .done(done), .nib_idx(nib_idx)
  );
  result_nibble_tx #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .load(load_m), .loadEn(loadEn_m), .nib_ready(ready_m),
    .nib_out(nib_out_m), .nib_valid(nib_valid_m), .busy(busy_m), .done(done_m), .nib_idx(nib_idx_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, b, c, d);
    q.push_back({2'd0, a}); q.push_back({2'd1, b}); q.push_back({2'd2, c}); q.push_back({2'd3, d});
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk) #1 load = w; loadEn = 1;
    @(posedge clk) #1 loadEn = 0; load = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 60 && (q.size() != 0 || busy); i++) @(negedge clk);
    chk("drain_timeout", {31'd0, busy}, 0);
    chk("drain_leftover", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  logic exp_done = 0, stall_prev = 0;
  logic [3:0] prev_nib;
  logic [1:0] prev_idx;
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst) begin
      exp_done = 0; stall_prev = 0;
    end else begin
      busy_cyc += int'(busy);
      chk("busy_eq_valid", {31'd0, busy}, {31'd0, nib_valid});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      exp_done = 0;
      if (stall_prev && nib_valid) begin
        chk("stall_nib", {28'd0, nib_out}, {28'd0, prev_nib});
        chk("stall_idx", {30'd0, nib_idx}, {30'd0, prev_idx});
      end
      if (nib_valid && nib_ready) begin
        if (q.size() == 0) chk("unexpected_nibble", {28'd0, nib_out}, 32'hdead);
        else begin
          e = q.pop_front();
          chk("nib", {28'd0, nib_out}, {28'd0, e[3:0]});
          chk("idx", {30'd0, nib_idx}, {30'd0, e[5:4]});
          exp_done = e[5:4] == 2'd3;
        end
      end
      stall_prev = nib_valid && !nib_ready;
      prev_nib = nib_out;
      prev_idx = nib_idx;
    end
  end

  logic exp_done_m = 0;
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst) exp_done_m = 0;
    else begin
      chk("m_done", {31'd0, done_m}, {31'd0, exp_done_m});
      exp_done_m = 0;
      if (nib_valid_m && ready_m) begin
        if (qm.size() == 0) chk("m_unexpected_nibble", {28'd0, nib_out_m}, 32'hdead);
        else begin
          e = qm.pop_front();
          chk("m_nib", {28'd0, nib_out_m}, {28'd0, e[3:0]});
          chk("m_idx", {30'd0, nib_idx_m}, {30'd0, e[5:4]});
          exp_done_m = e[5:4] == 2'd3;
        end
      end
    end
  end

  initial begin
    logic rp[7] = '{1, 0, 0, 1, 0, 1, 1};
    int b0;
    // 1: asynchronous reset clears everything mid-cycle, then idle stays idle
    #3 rst = 1;
    #1 chk("rst_valid", {31'd0, nib_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_nib", {28'd0, nib_out}, 0);
    chk("rst_idx", {30'd0, nib_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(negedge clk) chk("idle_valid", {31'd0, nib_valid}, 0);
    // 2: basic send of Q8.8 one
    push(4'h0, 4'h0, 4'h1, 4'h0);
    b0 = busy_cyc;
    send(Q88_ONE);
    drain();
    chk("t2_busy_cycles", busy_cyc - b0, 4);
    chk("t2_idle_nib", {28'd0, nib_out}, 0);
    // 3: backpressure
    push(4'h3, 4'hC, 4'h5, 4'hA);
    send(16'hA5C3);
    foreach (rp[i]) begin
      nib_ready = rp[i];
      @(posedge clk) #1;
    end
    nib_ready = 1;
    drain();
    // 4: load while busy is ignored
    push(4'h4, 4'h3, 4'h2, 4'h1);
    send(16'h1234);
    @(posedge clk) #1 load = 16'hFFFF; loadEn = 1;
    @(posedge clk) #1 loadEn = 0; load = 0;
    drain();
    // 5: back-to-back, second word loaded in the done cycle
    push(4'hF, 4'h0, 4'hF, 4'h0);
    push(4'hF, 4'hE, 4'hE, 4'hB);
    send(16'h0F0F);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("t5_done_seen", {31'd0, done}, 1);
    load = 16'hBEEF; loadEn = 1;
    @(posedge clk) #1 loadEn = 0; load = 0;
    chk("t5_second_busy", {31'd0, busy}, 1);
    drain();
    // 6: reset after two nibbles, then a normal send
    push(4'h4, 4'h3, 4'h2, 4'h1);
    send(16'h1234);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1;
    #1 chk("t6_valid", {31'd0, nib_valid}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_nib", {28'd0, nib_out}, 0);
    chk("t6_idx", {30'd0, nib_idx}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_consumed", q.size(), 2);
    q.delete();
    @(posedge clk) #1 rst = 0;
    push(4'h4, 4'h3, 4'h2, 4'h1);
    send(16'h1234);
    drain();
    // 6b: MSB-first build
    qm.push_back({2'd0, 4'h1}); qm.push_back({2'd1, 4'h2});
    qm.push_back({2'd2, 4'h3}); qm.push_back({2'd3, 4'h4});
    @(posedge clk) #1 load_m = 16'h1234; loadEn_m = 1;
    @(posedge clk) #1 loadEn_m = 0; load_m = 0;
    for (int i = 0; i < 40 && (qm.size() != 0 || busy_m); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("m_leftover", qm.size(), 0);
    chk("m_idle_nib", {28'd0, nib_out_m}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
